// File: rtl/int_to_float_pipe.sv
// Three-stage integer -> IEEE-754 single converter: negate/latch, normalise, round/pack.
// A single advance enable moves every stage together, so bubbles travel like data.
module int_to_float_pipe #(
  parameter int IN_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_WIDTH-1:0] in_data,
  input  logic                in_signed,
  input  logic [1:0]          in_rm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_data,
  output logic                out_inexact
);

  localparam int         LZW   = $clog2(IN_WIDTH);
  localparam logic [9:0] EBIAS = 10'(127 + IN_WIDTH - 1);

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RZ  = 2'b01;
  localparam logic [1:0] RM_RDN = 2'b10;

  logic                adv;
  logic [3:1]          vld_q;

  logic                s1_sign_d, s1_sign_q, s1_zero_d, s1_zero_q;
  logic [IN_WIDTH-1:0] s1_mag_d, s1_mag_q;
  logic [1:0]          s1_rm_q;

  logic                s2_sign_q, s2_zero_q;
  logic [1:0]          s2_rm_q;
  logic [IN_WIDTH-1:0] s2_norm_d, s2_norm_q;
  logic [LZW-1:0]      s2_lz_d, s2_lz_q;

  logic [IN_WIDTH+24:0] s3_ext;
  logic [22:0]          s3_frac;
  logic                 s3_g, s3_s, s3_nx, s3_up, s3_c;
  logic [23:0]          s3_sum;
  logic [9:0]           s3_exp;
  logic [31:0]          out_data_d, out_data_q;
  logic                 out_nx_d, out_nx_q;

  assign adv         = !vld_q[3] | out_ready;
  assign in_ready    = adv;
  assign out_valid   = vld_q[3];
  assign out_data    = out_data_q;
  assign out_inexact = out_nx_q;

  // Most-negative operand negates to itself, which read unsigned is exactly 2^(W-1).
  always_comb begin
    s1_sign_d = in_signed & in_data[IN_WIDTH-1];
    s1_mag_d  = s1_sign_d ? -in_data : in_data;
    s1_zero_d = (in_data == '0);
  end

  // Log2 shifter: each step clears the top 2^k bits if they are all zero.
  always_comb begin
    s2_norm_d = s1_mag_q;
    s2_lz_d   = '0;
    for (int k = LZW - 1; k >= 0; k--) begin
      if ((s2_norm_d >> (IN_WIDTH - (1 << k))) == '0) begin
        s2_norm_d  = s2_norm_d << (1 << k);
        s2_lz_d[k] = 1'b1;
      end
    end
  end

  always_comb begin
    s3_ext  = {s2_norm_q, 25'b0};
    s3_frac = s3_ext[IN_WIDTH+23 -: 23];
    s3_g    = s3_ext[IN_WIDTH];
    s3_s    = |s3_ext[IN_WIDTH-1:0];
    s3_nx   = s3_g | s3_s;
    case (s2_rm_q)
      RM_RNE:  s3_up = s3_g & (s3_s | s3_frac[0]);
      RM_RZ:   s3_up = 1'b0;
      RM_RDN:  s3_up = s2_sign_q & s3_nx;
      default: s3_up = !s2_sign_q & s3_nx;
    endcase
    s3_sum = {1'b0, s3_frac} + {23'b0, s3_up};
    s3_c   = s3_sum[23];
    s3_exp = EBIAS - 10'(s2_lz_q) + 10'(s3_c);
    if (s2_zero_q) begin
      out_data_d = 32'h0000_0000;
      out_nx_d   = 1'b0;
    end else begin
      out_data_d = {s2_sign_q, s3_exp[7:0], s3_c ? 23'b0 : s3_sum[22:0]};
      out_nx_d   = s3_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q      <= '0;
      out_data_q <= '0;
      out_nx_q   <= 1'b0;
    end else if (adv) begin
      vld_q <= {vld_q[2:1], in_valid};
      if (vld_q[2]) begin
        out_data_q <= out_data_d;
        out_nx_q   <= out_nx_d;
      end
    end
  end

  // Datapath stages carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sign_q <= s1_sign_d;
      s1_zero_q <= s1_zero_d;
      s1_mag_q  <= s1_mag_d;
      s1_rm_q   <= in_rm;
      s2_sign_q <= s1_sign_q;
      s2_zero_q <= s1_zero_q;
      s2_rm_q   <= s1_rm_q;
      s2_norm_q <= s2_norm_d;
      s2_lz_q   <= s2_lz_d;
    end
  end

endmodule

// File: tb/tb_int_to_float_pipe.sv
// Scoreboard bench: 32-, 64- and 16-bit builds driven in lockstep with one handshake.
// Expected results come from literal values or a remainder-vs-half rounding model.
module tb_int_to_float_pipe;

  typedef struct {
    logic [31:0] d;
    logic        nx;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_signed = 1'b0;
  logic [1:0]  in_rm = 2'b00;
  logic        out_ready = 1'b1;
  logic [31:0] in_d32 = '0;
  logic [63:0] in_d64 = '0;
  logic [15:0] in_d16 = '0;
  logic        ir32, ir64, ir16, ov32, ov64, ov16, nx32, nx64, nx16;
  logic [31:0] od32, od64, od16;

  exp_t q32[$];
  exp_t q64[$];
  exp_t q16[$];
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  int_to_float_pipe #(.IN_WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir32), .in_data(in_d32),
    .in_signed(in_signed), .in_rm(in_rm), .out_valid(ov32), .out_ready(out_ready),
    .out_data(od32), .out_inexact(nx32));
  int_to_float_pipe #(.IN_WIDTH(64)) u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir64), .in_data(in_d64),
    .in_signed(in_signed), .in_rm(in_rm), .out_valid(ov64), .out_ready(out_ready),
    .out_data(od64), .out_inexact(nx64));
  int_to_float_pipe #(.IN_WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir16), .in_data(in_d16),
    .in_signed(in_signed), .in_rm(in_rm), .out_valid(ov16), .out_ready(out_ready),
    .out_data(od16), .out_inexact(nx16));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [63:0] din, input int w, input logic sgn,
                                 input logic [1:0] rm);
    logic [63:0] mask, d, mag, rem, half, m;
    logic        s, up, nx;
    int          p, sh;
    exp_t        r;
    r.d  = '0;
    r.nx = 1'b0;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    d    = din & mask;
    s    = sgn & d[w-1];
    mag  = s ? ((~d + 64'd1) & mask) : d;
    if (mag == '0) return r;
    p = 0;
    for (int i = 0; i < 64; i++) if (mag[i]) p = i;
    nx = 1'b0;
    if (p <= 23) begin
      m = mag << (23 - p);
    end else begin
      sh   = p - 23;
      m    = mag >> sh;
      rem  = mag & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      nx   = (rem != '0);
      case (rm)
        2'd0:    up = (rem > half) || ((rem == half) && m[0]);
        2'd1:    up = 1'b0;
        2'd2:    up = s & nx;
        default: up = !s & nx;
      endcase
      m = m + {63'b0, up};
      if (m[24]) begin
        m = m >> 1;
        p++;
      end
    end
    r.d  = {s, 8'(p + 127), m[22:0]};
    r.nx = nx;
    return r;
  endfunction

  // lit=1: the 32-bit build is held to the given literal; other builds use the model.
  task automatic send(input logic [31:0] d, input logic sgn, input logic [1:0] rm,
                      input logic lit, input logic [31:0] ed, input logic enx);
    int   n;
    logic acc;
    exp_t e;
    n         = 0;
    acc       = 1'b0;
    in_valid  = 1'b1;
    in_d32    = d;
    in_d64    = sgn ? {{32{d[31]}}, d} : {32'b0, d};
    in_d16    = d[15:0];
    in_signed = sgn;
    in_rm     = rm;
    while (!acc && n < 50) begin
      @(negedge clk);
      if (ir32) begin
        acc = 1'b1;
        if (lit) begin
          e.d  = ed;
          e.nx = enx;
        end else e = model({32'b0, d}, 32, sgn, rm);
        q32.push_back(e);
        q64.push_back(model(in_d64, 64, sgn, rm));
        q16.push_back(model({48'b0, in_d16}, 16, sgn, rm));
      end
      @(posedge clk); #1;
      n++;
    end
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pop_cmp(input int w, input logic [31:0] od, input logic onx);
    exp_t e;
    int   sz;
    case (w)
      32:      sz = q32.size();
      64:      sz = q64.size();
      default: sz = q16.size();
    endcase
    if (sz == 0) begin
      chk($sformatf("w%0d_unexpected_out", w), 1, 0);
      return;
    end
    case (w)
      32:      e = q32.pop_front();
      64:      e = q64.pop_front();
      default: e = q16.pop_front();
    endcase
    chk($sformatf("w%0d_data", w), {32'b0, od}, {32'b0, e.d});
    chk($sformatf("w%0d_nx", w), {63'b0, onx}, {63'b0, e.nx});
  endtask

  // Output monitor: consumes results at transfer and checks stall stability.
  initial begin
    logic [31:0] hold_d;
    logic        hold_nx, hold_v;
    hold_v = 1'b0;
    hold_d = '0;
    hold_nx = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) hold_v = 1'b0;
      else begin
        if (hold_v) begin
          chk("stall_hold_data", {32'b0, od32}, {32'b0, hold_d});
          chk("stall_hold_nx", {63'b0, nx32}, {63'b0, hold_nx});
        end
        if (ov32 && !out_ready) begin
          chk("stall_in_ready", {61'b0, ir32, ir64, ir16}, 64'd0);
          hold_v  = 1'b1;
          hold_d  = od32;
          hold_nx = nx32;
        end else hold_v = 1'b0;
        if (ov32 && out_ready) pop_cmp(32, od32, nx32);
        if (ov64 && out_ready) pop_cmp(64, od64, nx64);
        if (ov16 && out_ready) pop_cmp(16, od16, nx16);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int stale;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {61'b0, ov32, ov64, ov16}, 64'd0);
    chk("rst_out_data", {32'b0, od32}, 64'd0);
    chk("rst_out_nx", {63'b0, nx32}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency: presented in cycle 0, out_valid first seen in cycle 3.
    send(32'd1, 1'b1, 2'd0, 1'b1, 32'h3F80_0000, 1'b0);
    in_valid = 1'b0;
    chk("lat_c1", {63'b0, ov32}, 64'd0);
    @(posedge clk); #1;
    chk("lat_c2", {63'b0, ov32}, 64'd0);
    @(posedge clk); #1;
    chk("lat_c3", {63'b0, ov32}, 64'd1);
    idle(3);

    send(32'hFFFF_FFFF, 1'b1, 2'd0, 1'b1, 32'hBF80_0000, 1'b0);
    send(32'h8000_0000, 1'b1, 2'd0, 1'b1, 32'hCF00_0000, 1'b0);
    send(32'h8000_0000, 1'b0, 2'd0, 1'b1, 32'h4F00_0000, 1'b0);
    send(32'hFFFF_8000, 1'b1, 2'd0, 1'b0, 32'h0, 1'b0);
    for (int r = 0; r < 4; r++) send(32'h0, 1'b1, 2'(r), 1'b1, 32'h0000_0000, 1'b0);
    send(32'h0100_0001, 1'b1, 2'd0, 1'b1, 32'h4B80_0000, 1'b1);
    send(32'h0100_0001, 1'b1, 2'd1, 1'b1, 32'h4B80_0000, 1'b1);
    send(32'h0100_0001, 1'b1, 2'd2, 1'b1, 32'h4B80_0000, 1'b1);
    send(32'h0100_0001, 1'b1, 2'd3, 1'b1, 32'h4B80_0001, 1'b1);
    send(32'hFEFF_FFFF, 1'b1, 2'd2, 1'b1, 32'hCB80_0001, 1'b1);
    send(32'hFEFF_FFFF, 1'b1, 2'd3, 1'b1, 32'hCB80_0000, 1'b1);
    send(32'hFFFF_FFFF, 1'b0, 2'd0, 1'b1, 32'h4F80_0000, 1'b1);
    send(32'hFFFF_FFFF, 1'b0, 2'd1, 1'b1, 32'h4F7F_FFFF, 1'b1);
    idle(6);

    // Eight back-to-back ops with a 5-clock consumer stall mid-stream.
    fork
      begin
        for (int i = 0; i < 8; i++)
          send($urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0, 32'h0, 1'b0);
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(6);

    // Random stream under random backpressure.
    fork
      begin
        for (int i = 0; i < 24; i++)
          send($urandom >> $urandom_range(0, 31), 1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)), 1'b0, 32'h0, 1'b0);
        in_valid = 1'b0;
      end
      begin
        repeat (40) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    idle(8);

    // Reset with three items in flight: discarded, nothing emitted afterwards.
    send(32'd7, 1'b1, 2'd0, 1'b0, 32'h0, 1'b0);
    send(32'd9, 1'b1, 2'd0, 1'b0, 32'h0, 1'b0);
    send(32'd11, 1'b1, 2'd0, 1'b0, 32'h0, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    q32.delete();
    q64.delete();
    q16.delete();
    @(posedge clk); #1;
    chk("mid_rst_out_valid", {61'b0, ov32, ov64, ov16}, 64'd0);
    chk("mid_rst_out_data", {32'b0, od32}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    stale = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ov32 || ov64 || ov16) stale++;
    end
    chk("stale_after_rst", 64'(stale), 64'd0);

    send(32'hFFFF_FFFF, 1'b1, 2'd0, 1'b1, 32'hBF80_0000, 1'b0);
    in_valid = 1'b0;
    for (int i = 0; i < 50 && (q32.size() + q64.size() + q16.size()) != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", 64'(q32.size() + q64.size() + q16.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
